// File: rtl/inert_cal_multi_if.sv
// rtl/inert_cal_multi_if.sv - sample/command bundle between the read sequencer, calibration stage and flight controller
//
// Purpose: groups the calibration command, raw sample bus and corrected output bus.
// Signals:
//   strt_cal  master->slave  single-cycle pulse, start/restart calibration
//   raw_vld   master->slave  raw holds a new sample set
//   raw       master->slave  NUM_CH*WIDTH raw channels, channel k at [k*WIDTH +: WIDTH]
//   vld       slave->master  one-cycle pulse, out is valid
//   out       slave->master  NUM_CH*WIDTH corrected channels, same packing as raw
//   cal_busy  slave->master  calibration accumulating
//   cal_done  slave->master  calibration completed (level)
interface inert_cal_multi_if #(
  parameter int NUM_CH = 3,
  parameter int WIDTH  = 16
);
  logic                      strt_cal;
  logic                      raw_vld;
  logic [NUM_CH*WIDTH-1:0]   raw;
  logic                      vld;
  logic [NUM_CH*WIDTH-1:0]   out;
  logic                      cal_busy;
  logic                      cal_done;

  modport master (
    output strt_cal, raw_vld, raw,
    input  vld, out, cal_busy, cal_done
  );

  modport slave (
    input  strt_cal, raw_vld, raw,
    output vld, out, cal_busy, cal_done
  );
endinterface

// File: rtl/inert_cal_multi.sv
// rtl/inert_cal_multi.sv - multi-channel offset calibration and corrected output stage
//
// Purpose: on strt_cal, averages 2^L samples per channel into per-channel offsets,
// then outputs raw - offset (saturated or wrapped) with a one-cycle registered valid.
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset
//   bus  inert_cal_multi_if.slave (strt_cal, raw_vld, raw in; vld, out, cal_busy, cal_done out)
module inert_cal_multi #(
  parameter int NUM_CH   = 3,
  parameter int WIDTH    = 16,
  parameter int CAL_LOG2 = 10,
  parameter int FAST_SIM = 1,
  parameter int SAT_EN   = 1
) (
  input  logic               clk,
  input  logic               rst,
  inert_cal_multi_if.slave   bus
);

  localparam int L  = (FAST_SIM != 0) ? 4 : CAL_LOG2;
  localparam int AW = WIDTH + L;

  typedef enum logic [1:0] {
    S_RUN,
    S_CAL_ACC,
    S_CAL_FIN
  } state_t;

  state_t                    state_q, state_d;
  logic [L-1:0]              cnt_q, cnt_d;
  logic [AW-1:0]             acc_q [NUM_CH];
  logic [AW-1:0]             acc_d [NUM_CH];
  logic [WIDTH-1:0]          off_q [NUM_CH];
  logic [WIDTH-1:0]          off_d [NUM_CH];
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      vld_q, vld_d;
  logic [NUM_CH*WIDTH-1:0]   out_q, out_d;
  logic [NUM_CH*WIDTH-1:0]   corr;
  logic [WIDTH:0]            diff;

  // Corrected value for every channel, one bit wider than WIDTH so the
  // overflow of raw - offset is visible to the clamp.
  always_comb begin
    corr = '0;
    diff = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      diff = {bus.raw[k*WIDTH + WIDTH-1], bus.raw[k*WIDTH +: WIDTH]}
           - {off_q[k][WIDTH-1], off_q[k]};
      // Top two bits disagree: result left the WIDTH-bit signed range.
      if ((SAT_EN != 0) && (diff[WIDTH] != diff[WIDTH-1])) begin
        corr[k*WIDTH +: WIDTH] = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
        corr[k*WIDTH +: WIDTH] = diff[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    off_d   = off_q;
    busy_d  = busy_q;
    done_d  = done_q;
    vld_d   = 1'b0;
    out_d   = out_q;

    case (state_q)
      S_RUN: begin
        if (bus.raw_vld) begin
          vld_d = 1'b1;
          out_d = corr;
        end
        if (bus.strt_cal) begin
          state_d = S_CAL_ACC;
          cnt_d   = '0;
          acc_d   = '{default: '0};
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end

      S_CAL_ACC: begin
        // A sample arriving with strt_cal belongs to the aborted run, not the new one.
        if (bus.strt_cal) begin
          cnt_d = '0;
          acc_d = '{default: '0};
        end else if (bus.raw_vld) begin
          for (int k = 0; k < NUM_CH; k++) begin
            acc_d[k] = acc_q[k] + {{L{bus.raw[k*WIDTH + WIDTH-1]}}, bus.raw[k*WIDTH +: WIDTH]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {L{1'b1}}) begin
            state_d = S_CAL_FIN;
          end
        end
      end

      S_CAL_FIN: begin
        if (bus.strt_cal) begin
          state_d = S_CAL_ACC;
          cnt_d   = '0;
          acc_d   = '{default: '0};
        end else begin
          // Upper WIDTH bits of the sum are the arithmetic shift by L (floor mean).
          for (int k = 0; k < NUM_CH; k++) begin
            off_d[k] = acc_q[k][AW-1:L];
          end
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      acc_q   <= '{default: '0};
      off_q   <= '{default: '0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      off_q   <= off_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      out_q   <= out_d;
    end
  end

  assign bus.vld      = vld_q;
  assign bus.out      = out_q;
  assign bus.cal_busy = busy_q;
  assign bus.cal_done = done_q;

endmodule

// File: tb/tb_inert_cal_multi.sv
// tb/tb_inert_cal_multi.sv - directed self-checking bench for inert_cal_multi (saturating and wrapping instances)
module tb_inert_cal_multi;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  inert_cal_multi_if #(.NUM_CH(3), .WIDTH(16)) ifa ();
  inert_cal_multi_if #(.NUM_CH(3), .WIDTH(16)) ifb ();

  assign ifb.strt_cal = ifa.strt_cal;
  assign ifb.raw_vld  = ifa.raw_vld;
  assign ifb.raw      = ifa.raw;

  inert_cal_multi #(.NUM_CH(3), .WIDTH(16), .CAL_LOG2(10), .FAST_SIM(1), .SAT_EN(1)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  inert_cal_multi #(.NUM_CH(3), .WIDTH(16), .CAL_LOG2(10), .FAST_SIM(1), .SAT_EN(0)) u_dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] pk(input int a, input int b, input int c);
    return {c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [47:0] r);
    ifa.strt_cal = s;
    ifa.raw_vld  = v;
    ifa.raw      = r;
    @(posedge clk);
    #1;
  endtask

  // Full calibration: 16 samples alternating r0/r1, then the CAL_FIN cycle.
  task automatic run_cal(input string tag, input logic [47:0] r0, input logic [47:0] r1);
    step(1'b1, 1'b0, '0);
    chk1({tag, "_busy_start"}, ifa.cal_busy, 1'b1);
    chk1({tag, "_done_start"}, ifa.cal_done, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, (i % 2 == 1) ? r1 : r0);
      chk1({tag, "_vld_acc"}, ifa.vld, 1'b0);
      chk1({tag, "_busy_acc"}, ifa.cal_busy, 1'b1);
    end
    chk1({tag, "_done_fin"}, ifa.cal_done, 1'b0);
    step(1'b0, 1'b0, '0);
    chk1({tag, "_done_end"}, ifa.cal_done, 1'b1);
    chk1({tag, "_busy_end"}, ifa.cal_busy, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    ifa.strt_cal = 1'b0;
    ifa.raw_vld  = 1'b0;
    ifa.raw      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_vld", ifa.vld, 1'b0);
    chk("rst_out", ifa.out, '0);
    chk1("rst_busy", ifa.cal_busy, 1'b0);
    chk1("rst_done", ifa.cal_done, 1'b0);
    rst = 1'b0;

    // 1. pass-through with zero offsets
    step(1'b0, 1'b1, pk('h0123, 'hFFFE, 'h7FFF));
    chk1("pt_vld", ifa.vld, 1'b1);
    chk("pt_out", ifa.out, pk('h0123, 'hFFFE, 'h7FFF));
    chk("pt_out_wrap", ifb.out, pk('h0123, 'hFFFE, 'h7FFF));
    step(1'b0, 1'b0, '0);
    chk1("pt_vld_low", ifa.vld, 1'b0);
    chk("pt_hold", ifa.out, pk('h0123, 'hFFFE, 'h7FFF));

    // 2. basic calibration
    run_cal("cal", pk(100, -50, 7), pk(100, -50, 7));
    step(1'b0, 1'b1, pk(100, -50, 7));
    chk1("cal_vld", ifa.vld, 1'b1);
    chk("cal_zero", ifa.out, pk(0, 0, 0));
    step(1'b0, 1'b1, pk(110, -40, 7));
    chk("cal_delta", ifa.out, pk(10, 10, 0));

    // 3. floor rounding of the mean
    run_cal("floor", pk(10, -3, 0), pk(11, -4, 0));
    step(1'b0, 1'b1, pk(11, -4, 0));
    chk("floor_out", ifa.out, pk(1, 0, 0));

    // 4. saturation vs wrap
    run_cal("satp", pk(-100, 0, 0), pk(-100, 0, 0));
    step(1'b0, 1'b1, pk('h7FF0, 0, 0));
    chk("sat_pos", ifa.out, pk('h7FFF, 0, 0));
    chk("wrap_pos", ifb.out, pk('h8054, 0, 0));
    run_cal("satn", pk(100, 0, 0), pk(100, 0, 0));
    step(1'b0, 1'b1, pk('h8000, 0, 0));
    chk("sat_neg", ifa.out, pk('h8000, 0, 0));
    chk("wrap_neg", ifb.out, pk('h7F9C, 0, 0));

    // 5a. restart after 5 samples
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, pk(999, 0, 0));
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, pk(50, 0, 0));
    step(1'b0, 1'b0, '0);
    chk1("rs_done_early", ifa.cal_done, 1'b0);
    chk1("rs_busy_early", ifa.cal_busy, 1'b1);
    step(1'b0, 1'b1, pk(50, 0, 0));
    step(1'b0, 1'b0, '0);
    chk1("rs_done", ifa.cal_done, 1'b1);
    step(1'b0, 1'b1, pk(50, 0, 0));
    chk("rs_out", ifa.out, pk(0, 0, 0));

    // 5b. strt_cal coincident with raw_vld: that sample is not counted
    step(1'b1, 1'b1, pk(1000, 0, 0));
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, pk(60, 0, 0));
    step(1'b0, 1'b0, '0);
    chk1("co_done_early", ifa.cal_done, 1'b0);
    chk1("co_busy_early", ifa.cal_busy, 1'b1);
    step(1'b0, 1'b1, pk(60, 0, 0));
    step(1'b0, 1'b0, '0);
    chk1("co_done", ifa.cal_done, 1'b1);
    step(1'b0, 1'b1, pk(60, 0, 0));
    chk("co_out0", ifa.out, pk(0, 0, 0));
    step(1'b0, 1'b1, pk(61, 0, 0));
    chk("co_out1", ifa.out, pk(1, 0, 0));

    // 5c. asynchronous reset mid-calibration
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, pk(500, 0, 0));
    chk1("mr_busy_pre", ifa.cal_busy, 1'b1);
    rst = 1'b1;
    #2;
    chk1("mr_busy", ifa.cal_busy, 1'b0);
    chk1("mr_done", ifa.cal_done, 1'b0);
    chk1("mr_vld", ifa.vld, 1'b0);
    chk("mr_out", ifa.out, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b1, pk('h0123, 'hFFFE, 'h7FFF));
    chk1("mr_pt_vld", ifa.vld, 1'b1);
    chk("mr_pt_out", ifa.out, pk('h0123, 'hFFFE, 'h7FFF));

    // 6. recalibration keeps old offset until the new one completes
    run_cal("rc1", pk(100, 0, 0), pk(100, 0, 0));
    step(1'b0, 1'b1, pk(100, 0, 0));
    chk("rc1_out", ifa.out, pk(0, 0, 0));
    step(1'b1, 1'b0, '0);
    chk1("rc_done_fall", ifa.cal_done, 1'b0);
    chk1("rc_busy_rise", ifa.cal_busy, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, pk(200, 0, 0));
    step(1'b0, 1'b0, '0);
    chk1("rc2_done", ifa.cal_done, 1'b1);
    step(1'b0, 1'b1, pk(200, 0, 0));
    chk("rc2_out0", ifa.out, pk(0, 0, 0));
    step(1'b0, 1'b1, pk(100, 0, 0));
    chk("rc2_outn", ifa.out, pk(-100, 0, 0));
    step(1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
